keypad_scanner: RTL and testbench

Matrix-keypad front end that produces the 4-bit `key` code consumed by the alarm clock's FSM and key register.
- Drives a 4-row x 3-column keypad one column at a time and samples the rows.
- Debounces press and release.
- Holds the decoded digit on `key` while the key is held, and the no-key code otherwise.
- Sits between the board keypad pins and the clock top's `key` input.

---
 rtl/alarm_clock_pkg.sv | 78 +++++++
 rtl/row_sync.sv | 30 +++
 rtl/keypad_scanner.sv | 135 +++++++++++++
 tb/tb_keypad_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_clock_pkg.sv
// ---------------------------------------------------------------------------
// alarm_clock_pkg
// Shared definitions for the alarm clock keypad path:
//   NOKEY          - code presented on `key` when no valid digit is held
//   scan_state_t   - keypad scanner FSM states
//   keypad_decode  - (row index, col index) -> 4-bit key code, * and # -> NOKEY
//   row_low_pos    - finds the single low row in an active-low row pattern
//   col_index      - one-cold column drive -> column index
//   col_next       - next one-cold column in the scan rotation
// ---------------------------------------------------------------------------
package alarm_clock_pkg;

  localparam logic [3:0] NOKEY = 4'd10;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_t;

  // Keypad layout: r0 = 1 2 3, r1 = 4 5 6, r2 = 7 8 9, r3 = * 0 #
  function automatic logic [3:0] keypad_decode(input logic [1:0] row_idx,
                                               input logic [1:0] col_idx);
    logic [3:0] code;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_01: code = 4'd0;
      default:  code = NOKEY;  // *, # and the unused column index
    endcase
    return code;
  endfunction

  // Returns {valid, index}; valid only when exactly one row is low
  function automatic logic [2:0] row_low_pos(input logic [3:0] rows);
    logic [2:0] pos;
    case (rows)
      4'b1110: pos = {1'b1, 2'd0};
      4'b1101: pos = {1'b1, 2'd1};
      4'b1011: pos = {1'b1, 2'd2};
      4'b0111: pos = {1'b1, 2'd3};
      default: pos = {1'b0, 2'd0};
    endcase
    return pos;
  endfunction

  function automatic logic [1:0] col_index(input logic [2:0] col);
    logic [1:0] idx;
    case (col)
      3'b110:  idx = 2'd0;
      3'b101:  idx = 2'd1;
      3'b011:  idx = 2'd2;
      default: idx = 2'd3;  // never decodes to a digit
    endcase
    return idx;
  endfunction

  // An illegal column pattern recovers to column 0
  function automatic logic [2:0] col_next(input logic [2:0] col);
    logic [2:0] nxt;
    case (col)
      3'b110:  nxt = 3'b101;
      3'b101:  nxt = 3'b011;
      3'b011:  nxt = 3'b110;
      default: nxt = 3'b110;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/row_sync.sv
// ---------------------------------------------------------------------------
// row_sync
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-high (no key) so the scanner sees an idle keypad.
//   clock  in   system clock
//   reset  in   synchronous active-high reset
//   din    in   [3:0] raw keypad rows
//   dout   out  [3:0] synchronized rows (2-cycle latency)
// ---------------------------------------------------------------------------
module row_sync (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] din,
  output logic [3:0] dout
);

  logic [3:0] meta;

  // Two-stage synchronizer chain
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 4'hF;
      dout <= 4'hF;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
// 4x3 matrix keypad front end: scans one column at a time, debounces press
// and release, and holds the decoded digit while the key is down.
//   clock        in   system clock
//   reset        in   synchronous active-high reset
//   row          in   [3:0] keypad rows, active-low, asynchronous
//   col          out  [2:0] column drive, active-low, one-cold
//   key          out  [3:0] digit 0-9 while held, NOKEY otherwise
//   key_pressed  out  one-cycle pulse when a press is accepted
// ---------------------------------------------------------------------------
module keypad_scanner
  import alarm_clock_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_pressed
);

  localparam int DW  = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CNT - 1);

  logic [3:0]     row_s;
  scan_state_t    state;
  logic [DW-1:0]  dwell;
  logic [DBW-1:0] deb;
  logic [3:0]     cand;      // row pattern under debounce
  logic [3:0]     cand_key;  // its decoded digit, captured with it
  logic [2:0]     row_hit;
  logic [3:0]     cand_code;
  logic           scan_ok;

  row_sync u_row_sync (
    .clock (clock),
    .reset (reset),
    .din   (row),
    .dout  (row_s)
  );

  // Decode the synchronized rows against the column currently driven
  always_comb begin
    row_hit   = row_low_pos(row_s);
    cand_code = keypad_decode(row_hit[1:0], col_index(col));
    scan_ok   = row_hit[2] && (cand_code != NOKEY);
  end

  // Scanner FSM with registered column drive, key and press pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= SCAN;
      col         <= 3'b110;
      dwell       <= '0;
      deb         <= '0;
      cand        <= 4'hF;
      cand_key    <= NOKEY;
      key         <= NOKEY;
      key_pressed <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      case (state)
        SCAN: begin
          // Rows are only judged at the end of the dwell, after the
          // synchronizer has caught up with the new column
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (scan_ok) begin
              cand     <= row_s;
              cand_key <= cand_code;
              deb      <= '0;
              state    <= DEBOUNCE;
            end else begin
              col <= col_next(col);
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_s == cand) begin
            if (deb == DEB_LAST) begin
              key         <= cand_key;
              key_pressed <= 1'b1;
              state       <= PRESSED;
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            dwell <= '0;
            col   <= col_next(col);
            state <= SCAN;
          end
        end
        PRESSED: begin
          // Rollover (extra rows low) is ignored; only all-high counts
          if (row_s == 4'hF) begin
            deb   <= '0;
            state <= RELEASE;
          end else begin
            state <= PRESSED;
          end
        end
        RELEASE: begin
          if (row_s == 4'hF) begin
            if (deb == DEB_LAST) begin
              key   <= NOKEY;
              dwell <= '0;
              col   <= col_next(col);
              state <= SCAN;
            end else begin
              deb <= deb + 1'b1;
            end
          end else begin
            // Release glitch: back to held, key unchanged, no new pulse
            state <= PRESSED;
          end
        end
        default: begin
          state <= SCAN;
          col   <= 3'b110;
          dwell <= '0;
          key   <= NOKEY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=8 and a
// keypad model that pulls a row low when a pressed key's column is driven.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key;
  logic        key_pressed;
  logic [11:0] keys;    // pressed switches, bit = r*3 + c
  int          checks;
  int          errors;
  int          pulses;  // key_pressed pulses seen by the monitor
  int          snap;

  keypad_scanner #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CNT (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key         (key),
    .key_pressed (key_pressed)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a row goes low when any pressed key on it has its column driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (keys[r*3 + c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  // Count press pulses on the falling edge
  always @(negedge clock) begin
    if (key_pressed === 1'b1) pulses <= pulses + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_key(input string tag, input logic [3:0] exp, input int budget);
    int n;
    n = 0;
    while (key !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, {4'd0, key}, {4'd0, exp});
  endtask

  task automatic wait_col(input string tag, input logic [2:0] exp, input int budget);
    int n;
    n = 0;
    while (col !== exp && n < budget) begin
      tick();
      n++;
    end
    check(tag, {5'd0, col}, {5'd0, exp});
  endtask

  logic [2:0] col_seq [0:3];

  initial begin
    clock  = 1'b0;
    reset  = 1'b1;
    keys   = 12'd0;
    checks = 0;
    errors = 0;
    pulses = 0;
    col_seq[0] = 3'b110;
    col_seq[1] = 3'b101;
    col_seq[2] = 3'b011;
    col_seq[3] = 3'b110;

    // 1. Reset state and column rotation every 4 cycles
    repeat (3) tick();
    check("rst_col", {5'd0, col}, 8'h06);
    check("rst_key", {4'd0, key}, 8'd10);
    check("rst_kp",  {7'd0, key_pressed}, 8'd0);
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check("rotate", {5'd0, col}, {5'd0, col_seq[n/4]});
    end

    // 2. Clean press of 5 (r1,c1), held 40 cycles, then released
    snap = pulses;
    keys = 12'b0000_0001_0000;
    repeat (40) tick();
    check("p5_key",    {4'd0, key}, 8'd5);
    check("p5_col",    {5'd0, col}, 8'h05);
    check("p5_pulses", 8'(pulses - snap), 8'd1);
    keys = 12'd0;
    // 2 sync cycles + 1 to enter RELEASE + 8 debounce cycles
    repeat (10) tick();
    check("r5_still", {4'd0, key}, 8'd5);
    tick();
    check("r5_key",    {4'd0, key}, 8'd10);
    check("r5_col",    {5'd0, col}, 8'h03);
    check("r5_pulses", 8'(pulses - snap), 8'd1);

    // 3. Bouncy press of 9 (r2,c2), toggling every 3 cycles
    snap = pulses;
    for (int i = 0; i < 20; i++) begin
      keys = (((i / 3) % 2) == 0) ? 12'b0001_0000_0000 : 12'd0;
      tick();
    end
    keys = 12'b0001_0000_0000;
    repeat (8) tick();
    check("b9_nopulse", 8'(pulses - snap), 8'd0);
    wait_key("b9_key", 4'd9, 40);
    check("b9_kp", {7'd0, key_pressed}, 8'd1);
    repeat (2) tick();
    check("b9_pulses", 8'(pulses - snap), 8'd1);
    keys = 12'd0;
    wait_key("b9_rel", 4'd10, 30);

    // 4. Two keys in one column, then * and #
    snap = pulses;
    keys = 12'b0000_0000_1001;
    repeat (30) tick();
    check("k14_key", {4'd0, key}, 8'd10);
    check("k14_kp",  8'(pulses - snap), 8'd0);
    keys = 12'b0010_0000_0000;
    repeat (30) tick();
    check("star_key", {4'd0, key}, 8'd10);
    check("star_kp",  8'(pulses - snap), 8'd0);
    keys = 12'b1000_0000_0000;
    repeat (30) tick();
    check("hash_key", {4'd0, key}, 8'd10);
    check("hash_kp",  8'(pulses - snap), 8'd0);
    keys = 12'd0;
    repeat (4) tick();

    // 5. Release glitch while 0 (r3,c1) is held
    snap = pulses;
    keys = 12'b0100_0000_0000;
    wait_key("k0_key", 4'd0, 40);
    repeat (5) tick();
    keys = 12'd0;
    repeat (3) tick();
    keys = 12'b0100_0000_0000;
    repeat (5) tick();
    check("glitch_key", {4'd0, key}, 8'd0);
    repeat (20) tick();
    check("glitch_hold",   {4'd0, key}, 8'd0);
    check("glitch_pulses", 8'(pulses - snap), 8'd1);
    keys = 12'd0;
    wait_key("k0_rel", 4'd10, 30);

    // 6. Reset while debouncing 3 (r0,c2)
    wait_col("d3_sync0", 3'b110, 20);
    snap = pulses;
    keys = 12'b0000_0000_0100;
    wait_col("d3_col1", 3'b101, 20);
    wait_col("d3_col2", 3'b011, 20);
    // Capture happens 4 cycles after column 2 is driven; col would rotate otherwise
    repeat (5) tick();
    check("d3_frozen", {5'd0, col}, 8'h03);
    check("d3_key",    {4'd0, key}, 8'd10);
    reset = 1'b1;
    tick();
    check("d3_rst_col", {5'd0, col}, 8'h06);
    check("d3_rst_key", {4'd0, key}, 8'd10);
    check("d3_rst_kp",  {7'd0, key_pressed}, 8'd0);
    reset = 1'b0;
    repeat (2) tick();
    check("d3_nopulse", 8'(pulses - snap), 8'd0);
    wait_key("d3_redetect", 4'd3, 40);
    tick();
    check("d3_kp_once", {7'd0, key_pressed}, 8'd0);
    tick();
    check("d3_pulses", 8'(pulses - snap), 8'd1);
    keys = 12'd0;
    wait_key("d3_rel", 4'd10, 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
